id_ex_pipeline: RTL and testbench
=================================

Name: id_ex_pipeline

Overview:
- ID/EX pipeline register for the pipelined MIPS datapath; sits directly downstream of the decode control unit and register file.
- Captures the decode control bundle, operands and register indices each cycle and presents them to the EX stage.
- Contains a load-use hazard detector; on a hazard it requests a one-cycle stall from the fetch/decode stages and inserts a bubble into EX.
- Supports flush from branch resolution and keeps a saturating count of inserted bubbles.

Parameters:
NBITS, 32, datapath width of operands, immediate and PC+4
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Flush  input  1  kill instruction entering EX (branch/jump taken)
RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JumpR  input  1 each  decode control signals
ALUOp  input  3  decode ALU operation
ALUFunction  input  6  funct field
ReadData1, ReadData2  input  NBITS  register file outputs
SignExtImm  input  NBITS  sign-extended immediate
PC_4  input  NBITS  PC+4 of decoded instruction
Rs, Rt, Rd  input  5 each  register indices of decoded instruction
EX_RegDst, EX_BranchEQ, EX_BranchNE, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite, EX_JumpR  output  1 each  registered control
EX_ALUOp  output  3  registered ALU op
EX_ALUFunction  output  6  registered funct
EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC_4  output  NBITS  registered data
EX_Rs, EX_Rt, EX_Rd  output  5 each  registered indices
EX_Valid  output  1  1 = real instruction in EX, 0 = bubble
Stall  output  1  combinational; hold PC and IF/ID this cycle
BubbleCount  output  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (sync, active-high, highest priority): all EX_* outputs 0, EX_Valid 0, BubbleCount 0. Stall is combinational from registered state and is therefore 0 after reset.
- Hazard: Stall = EX_MemRead & EX_Valid & (EX_Rt != 0) & ((EX_Rt == Rs) | ((EX_Rt == Rt) & (RegDst | MemWrite | BranchEQ | BranchNE))). Rt is only a source for R-type, SW and branches.
- Per rising edge, in priority order:
  1. reset: clear everything.
  2. Flush=1: control outputs (EX_RegDst..EX_JumpR, EX_ALUOp) <= 0; EX_Valid <= 0; data/index fields load inputs normally. BubbleCount is not incremented.
  3. Stall=1: same bubble load as Flush; BubbleCount increments.
  4. Otherwise: all fields load inputs; EX_Valid <= 1.
- Latency: 1 cycle, input to EX_* output.
- Load-use stall lasts exactly 1 cycle: the bubble clears EX_MemRead, so Stall deasserts the next cycle and the held instruction enters EX.
- Flush and Stall in the same cycle: Flush wins; no count increment.
- BubbleCount saturates at 2^CNT_W-1 and does not wrap.
- Rt=0 destination never triggers a stall.
- Reset mid-stall: next cycle the outputs are cleared and Stall=0.
- No internal storage beyond the register fields and counter; the module does not gate the upstream registers, the consumer uses Stall.

Test Plan:
- Reset asserted 2 cycles with random inputs -> all EX_* = 0, EX_Valid=0, Stall=0, BubbleCount=0.
- ADDI (ALUSrc=1, RegWrite=1, ALUOp=3'b100, Rs=8, Rt=9, SignExtImm=32'h5) -> next cycle EX_ALUSrc=1, EX_ALUOp=3'b100, EX_SignExtImm=5, EX_Valid=1, Stall=0.
- LW Rt=9 in EX, then R-type Rs=9 in decode -> Stall=1 one cycle; EX gets bubble (EX_RegWrite=0, EX_Valid=0); BubbleCount=1; following cycle Stall=0 and R-type loads.
- LW Rt=9 in EX, then ADDI Rt=9 (RegDst=0, no MemWrite/branch) -> Stall=0 (Rt is a destination, not a source).
- LW Rt=0 in EX, then R-type Rs=0 -> Stall=0.
- Hazard present and Flush=1 same cycle -> EX_Valid=0, control zeroed, BubbleCount unchanged. Separately, with CNT_W=2, force 5 stalls -> BubbleCount holds 3.

Source files
------------

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use hazard detection, flush and a saturating bubble counter.
// Latency: 1 cycle from the decode inputs to the EX_* outputs.
// Backpressure: Stall is combinational from EX state and decode inputs. It holds PC and IF/ID upstream while a bubble enters EX.
//
// Ports:
//   clk, reset      rising-edge clock and synchronous active-high reset
//   Flush           kills the instruction entering EX (taken branch or jump)
//   decode inputs   control bundle, ALUOp/ALUFunction, operands, immediate, PC+4, Rs/Rt/Rd
//   EX_* outputs    registered copies of the decode inputs; EX_Valid=0 marks a bubble
//   Stall           load-use hazard request to the fetch/decode stages
//   BubbleCount     saturating count of stall bubbles since reset (flushes are not counted)
module id_ex_pipeline #(
  parameter int NBITS = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             RegDst,
  input  logic             BranchEQ,
  input  logic             BranchNE,
  input  logic             MemRead,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             ALUSrc,
  input  logic             RegWrite,
  input  logic             JumpR,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       ALUFunction,
  input  logic [NBITS-1:0] ReadData1,
  input  logic [NBITS-1:0] ReadData2,
  input  logic [NBITS-1:0] SignExtImm,
  input  logic [NBITS-1:0] PC_4,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic [4:0]       Rd,
  output logic             EX_RegDst,
  output logic             EX_BranchEQ,
  output logic             EX_BranchNE,
  output logic             EX_MemRead,
  output logic             EX_MemtoReg,
  output logic             EX_MemWrite,
  output logic             EX_ALUSrc,
  output logic             EX_RegWrite,
  output logic             EX_JumpR,
  output logic [2:0]       EX_ALUOp,
  output logic [5:0]       EX_ALUFunction,
  output logic [NBITS-1:0] EX_ReadData1,
  output logic [NBITS-1:0] EX_ReadData2,
  output logic [NBITS-1:0] EX_SignExtImm,
  output logic [NBITS-1:0] EX_PC_4,
  output logic [4:0]       EX_Rs,
  output logic [4:0]       EX_Rt,
  output logic [4:0]       EX_Rd,
  output logic             EX_Valid,
  output logic             Stall,
  output logic [CNT_W-1:0] BubbleCount
);

  // Fields zeroed when a bubble is inserted.
  typedef struct packed {
    logic       reg_dst;
    logic       branch_eq;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump_r;
    logic [2:0] alu_op;
  } ctrl_t;

  // Fields that always load, bubble or not.
  typedef struct packed {
    logic [5:0]       alu_function;
    logic [NBITS-1:0] read_data1;
    logic [NBITS-1:0] read_data2;
    logic [NBITS-1:0] sign_ext_imm;
    logic [NBITS-1:0] pc_4;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
  } dat_t;

  ctrl_t            ctrl_in;
  ctrl_t            ctrl_d, ctrl_q;
  dat_t             dat_d, dat_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             rt_is_src;
  logic             stall;

  assign ctrl_in = '{reg_dst: RegDst, branch_eq: BranchEQ, branch_ne: BranchNE,
                     mem_read: MemRead, mem_to_reg: MemtoReg, mem_write: MemWrite,
                     alu_src: ALUSrc, reg_write: RegWrite, jump_r: JumpR, alu_op: ALUOp};

  // Rt is read only by R-type, stores and branches. For other instructions it is a destination.
  assign rt_is_src = RegDst | MemWrite | BranchEQ | BranchNE;

  // Load in EX whose destination is read by the instruction in decode. $zero is never a real dependency.
  assign stall = ctrl_q.mem_read & valid_q & (dat_q.rt != 5'd0) &
                 ((dat_q.rt == Rs) | ((dat_q.rt == Rt) & rt_is_src));

  always_comb begin
    ctrl_d       = ctrl_in;
    valid_d      = 1'b1;
    bubble_cnt_d = bubble_cnt_q;
    dat_d        = '{alu_function: ALUFunction, read_data1: ReadData1, read_data2: ReadData2,
                     sign_ext_imm: SignExtImm, pc_4: PC_4, rs: Rs, rt: Rt, rd: Rd};
    if (Flush) begin
      // A flush bubble replaces a killed instruction, so it is not counted as a stall.
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= '0;
      dat_q        <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      dat_q        <= dat_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign EX_RegDst      = ctrl_q.reg_dst;
  assign EX_BranchEQ    = ctrl_q.branch_eq;
  assign EX_BranchNE    = ctrl_q.branch_ne;
  assign EX_MemRead     = ctrl_q.mem_read;
  assign EX_MemtoReg    = ctrl_q.mem_to_reg;
  assign EX_MemWrite    = ctrl_q.mem_write;
  assign EX_ALUSrc      = ctrl_q.alu_src;
  assign EX_RegWrite    = ctrl_q.reg_write;
  assign EX_JumpR       = ctrl_q.jump_r;
  assign EX_ALUOp       = ctrl_q.alu_op;
  assign EX_ALUFunction = dat_q.alu_function;
  assign EX_ReadData1   = dat_q.read_data1;
  assign EX_ReadData2   = dat_q.read_data2;
  assign EX_SignExtImm  = dat_q.sign_ext_imm;
  assign EX_PC_4        = dat_q.pc_4;
  assign EX_Rs          = dat_q.rs;
  assign EX_Rt          = dat_q.rt;
  assign EX_Rd          = dat_q.rd;
  assign EX_Valid       = valid_q;
  assign Stall          = stall;
  assign BubbleCount    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline.sv
module tb_id_ex_pipeline;
  localparam int NBITS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, Flush;
  logic RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JumpR;
  logic [2:0] ALUOp;
  logic [5:0] ALUFunction;
  logic [NBITS-1:0] ReadData1, ReadData2, SignExtImm, PC_4;
  logic [4:0] Rs, Rt, Rd;

  logic EX_RegDst, EX_BranchEQ, EX_BranchNE, EX_MemRead, EX_MemtoReg, EX_MemWrite, EX_ALUSrc, EX_RegWrite, EX_JumpR;
  logic [2:0] EX_ALUOp;
  logic [5:0] EX_ALUFunction;
  logic [NBITS-1:0] EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC_4;
  logic [4:0] EX_Rs, EX_Rt, EX_Rd;
  logic EX_Valid, Stall;
  logic [15:0] BubbleCount;

  // Second instance with a 2-bit counter for saturation.
  logic s_RegDst, s_BranchEQ, s_BranchNE, s_MemRead, s_MemtoReg, s_MemWrite, s_ALUSrc, s_RegWrite, s_JumpR;
  logic [2:0] s_ALUOp;
  logic [5:0] s_ALUFunction;
  logic [NBITS-1:0] s_ReadData1, s_ReadData2, s_SignExtImm, s_PC_4;
  logic [4:0] s_Rs, s_Rt, s_Rd;
  logic s_Valid, s_Stall;
  logic [1:0] s_BubbleCount;

  id_ex_pipeline #(.NBITS(NBITS), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Flush(Flush),
    .RegDst(RegDst), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .JumpR(JumpR),
    .ALUOp(ALUOp), .ALUFunction(ALUFunction), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .SignExtImm(SignExtImm), .PC_4(PC_4), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .EX_RegDst(EX_RegDst), .EX_BranchEQ(EX_BranchEQ), .EX_BranchNE(EX_BranchNE),
    .EX_MemRead(EX_MemRead), .EX_MemtoReg(EX_MemtoReg), .EX_MemWrite(EX_MemWrite),
    .EX_ALUSrc(EX_ALUSrc), .EX_RegWrite(EX_RegWrite), .EX_JumpR(EX_JumpR),
    .EX_ALUOp(EX_ALUOp), .EX_ALUFunction(EX_ALUFunction), .EX_ReadData1(EX_ReadData1),
    .EX_ReadData2(EX_ReadData2), .EX_SignExtImm(EX_SignExtImm), .EX_PC_4(EX_PC_4),
    .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Valid(EX_Valid), .Stall(Stall),
    .BubbleCount(BubbleCount)
  );

  id_ex_pipeline #(.NBITS(NBITS), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Flush(Flush),
    .RegDst(RegDst), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .JumpR(JumpR),
    .ALUOp(ALUOp), .ALUFunction(ALUFunction), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .SignExtImm(SignExtImm), .PC_4(PC_4), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .EX_RegDst(s_RegDst), .EX_BranchEQ(s_BranchEQ), .EX_BranchNE(s_BranchNE),
    .EX_MemRead(s_MemRead), .EX_MemtoReg(s_MemtoReg), .EX_MemWrite(s_MemWrite),
    .EX_ALUSrc(s_ALUSrc), .EX_RegWrite(s_RegWrite), .EX_JumpR(s_JumpR),
    .EX_ALUOp(s_ALUOp), .EX_ALUFunction(s_ALUFunction), .EX_ReadData1(s_ReadData1),
    .EX_ReadData2(s_ReadData2), .EX_SignExtImm(s_SignExtImm), .EX_PC_4(s_PC_4),
    .EX_Rs(s_Rs), .EX_Rt(s_Rt), .EX_Rd(s_Rd), .EX_Valid(s_Valid), .Stall(s_Stall),
    .BubbleCount(s_BubbleCount)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Flush = 0; RegDst = 0; BranchEQ = 0; BranchNE = 0; MemRead = 0; MemtoReg = 0;
    MemWrite = 0; ALUSrc = 0; RegWrite = 0; JumpR = 0; ALUOp = 0; ALUFunction = 0;
    ReadData1 = 0; ReadData2 = 0; SignExtImm = 0; PC_4 = 0; Rs = 0; Rt = 0; Rd = 0;
  endtask

  // lw $rt, 0($rs)
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    clr();
    MemRead = 1; MemtoReg = 1; ALUSrc = 1; RegWrite = 1; ALUOp = 3'b100;
    Rs = rs; Rt = rt; SignExtImm = 32'h10; PC_4 = 32'h200;
  endtask

  // add $rd, $rs, $rt
  task automatic drive_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clr();
    RegDst = 1; RegWrite = 1; ALUOp = 3'b000; ALUFunction = 6'h20;
    Rs = rs; Rt = rt; Rd = rd; ReadData1 = 32'hAAAA_0001; ReadData2 = 32'h5555_0002; PC_4 = 32'h204;
  endtask

  initial begin
    // Reset held two cycles with random inputs.
    reset = 1;
    clr();
    {RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, JumpR} = 9'($urandom);
    ALUOp = 3'($urandom); ALUFunction = 6'($urandom);
    ReadData1 = $urandom; ReadData2 = $urandom; SignExtImm = $urandom; PC_4 = $urandom;
    Rs = 5'($urandom); Rt = 5'($urandom); Rd = 5'($urandom);
    tick();
    tick();
    chk("rst_ctrl", 64'({EX_RegDst, EX_BranchEQ, EX_BranchNE, EX_MemRead, EX_MemtoReg, EX_MemWrite,
                         EX_ALUSrc, EX_RegWrite, EX_JumpR, EX_ALUOp, EX_ALUFunction}), 64'd0);
    chk("rst_data", 64'(EX_ReadData1 | EX_ReadData2 | EX_SignExtImm | EX_PC_4), 64'd0);
    chk("rst_idx", 64'({EX_Rs, EX_Rt, EX_Rd}), 64'd0);
    chk("rst_valid", 64'(EX_Valid), 64'd0);
    chk("rst_stall", 64'(Stall), 64'd0);
    chk("rst_count", 64'(BubbleCount), 64'd0);

    // ADDI $9, $8, 5
    @(negedge clk);
    reset = 0;
    clr();
    ALUSrc = 1; RegWrite = 1; ALUOp = 3'b100; Rs = 8; Rt = 9; SignExtImm = 32'h5; PC_4 = 32'h104;
    tick();
    chk("addi_alusrc", 64'(EX_ALUSrc), 64'd1);
    chk("addi_aluop", 64'(EX_ALUOp), 64'd4);
    chk("addi_imm", 64'(EX_SignExtImm), 64'd5);
    chk("addi_pc4", 64'(EX_PC_4), 64'h104);
    chk("addi_rt", 64'(EX_Rt), 64'd9);
    chk("addi_valid", 64'(EX_Valid), 64'd1);
    chk("addi_stall", 64'(Stall), 64'd0);

    // LW $9 then dependent R-type reading $9 through Rs: one-cycle stall.
    @(negedge clk);
    drive_lw(8, 9);
    tick();
    chk("lw_memread", 64'(EX_MemRead), 64'd1);
    @(negedge clk);
    drive_rtype(9, 10, 11);
    #1;
    chk("lu_stall", 64'(Stall), 64'd1);
    tick();
    chk("lu_bubble_valid", 64'(EX_Valid), 64'd0);
    chk("lu_bubble_regwrite", 64'(EX_RegWrite), 64'd0);
    chk("lu_bubble_memread", 64'(EX_MemRead), 64'd0);
    chk("lu_bubble_rs", 64'(EX_Rs), 64'd9);
    chk("lu_count", 64'(BubbleCount), 64'd1);
    chk("lu_stall_clear", 64'(Stall), 64'd0);
    tick();
    chk("lu_rtype_valid", 64'(EX_Valid), 64'd1);
    chk("lu_rtype_regdst", 64'(EX_RegDst), 64'd1);
    chk("lu_rtype_funct", 64'(EX_ALUFunction), 64'h20);
    chk("lu_rtype_rd1", 64'(EX_ReadData1), 64'hAAAA_0001);
    chk("lu_rtype_rd", 64'(EX_Rd), 64'd11);
    chk("lu_count_hold", 64'(BubbleCount), 64'd1);

    // LW $9 then ADDI writing $9: Rt is a destination, so there is no stall.
    @(negedge clk);
    drive_lw(8, 9);
    tick();
    @(negedge clk);
    clr();
    ALUSrc = 1; RegWrite = 1; ALUOp = 3'b100; Rs = 8; Rt = 9; SignExtImm = 32'h7;
    #1;
    chk("addi_rt_dest_stall", 64'(Stall), 64'd0);
    MemWrite = 1; RegWrite = 0;
    #1;
    chk("sw_rt_src_stall", 64'(Stall), 64'd1);
    MemWrite = 0; BranchEQ = 1;
    #1;
    chk("beq_rt_src_stall", 64'(Stall), 64'd1);
    BranchEQ = 0; RegWrite = 1;
    tick();
    chk("addi_rt_dest_valid", 64'(EX_Valid), 64'd1);
    chk("addi_rt_dest_imm", 64'(EX_SignExtImm), 64'd7);
    chk("addi_rt_dest_count", 64'(BubbleCount), 64'd1);

    // LW $0 then R-type reading $0: no stall.
    @(negedge clk);
    drive_lw(8, 0);
    tick();
    @(negedge clk);
    drive_rtype(0, 0, 12);
    #1;
    chk("rt0_stall", 64'(Stall), 64'd0);
    tick();
    chk("rt0_valid", 64'(EX_Valid), 64'd1);

    // Hazard and flush in the same cycle: flush wins and nothing is counted.
    @(negedge clk);
    drive_lw(8, 9);
    tick();
    @(negedge clk);
    drive_rtype(9, 3, 4);
    ALUOp = 3'b010;
    Flush = 1;
    #1;
    chk("flush_hazard_stall", 64'(Stall), 64'd1);
    tick();
    chk("flush_valid", 64'(EX_Valid), 64'd0);
    chk("flush_ctrl", 64'({EX_RegDst, EX_RegWrite, EX_MemRead, EX_ALUOp}), 64'd0);
    chk("flush_rd", 64'(EX_Rd), 64'd4);
    chk("flush_count", 64'(BubbleCount), 64'd1);
    chk("flush_count_sat", 64'(s_BubbleCount), 64'd1);
    Flush = 0;

    // Four more load-use stalls: the 16-bit counter reaches 5 and the 2-bit one holds at 3.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_lw(8, 9);
      tick();
      @(negedge clk);
      drive_rtype(9, 10, 11);
      #1;
      chk("loop_stall", 64'(Stall), 64'd1);
      tick();
      chk("loop_count", 64'(BubbleCount), 64'(i + 2));
      chk("loop_count_sat", 64'(s_BubbleCount), 64'((i + 2) > 3 ? 3 : (i + 2)));
    end
    chk("sat_final", 64'(s_BubbleCount), 64'd3);
    chk("count_final", 64'(BubbleCount), 64'd5);

    // Reset asserted while a stall is pending.
    @(negedge clk);
    drive_lw(8, 9);
    tick();
    @(negedge clk);
    drive_rtype(9, 10, 11);
    #1;
    chk("midstall_stall_before", 64'(Stall), 64'd1);
    reset = 1;
    tick();
    chk("midstall_valid", 64'(EX_Valid), 64'd0);
    chk("midstall_stall", 64'(Stall), 64'd0);
    chk("midstall_ctrl", 64'({EX_RegDst, EX_RegWrite, EX_MemRead, EX_ALUOp, EX_Rs}), 64'd0);
    chk("midstall_count", 64'(BubbleCount), 64'd0);
    chk("midstall_count_sat", 64'(s_BubbleCount), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
